// File: rtl/pc_sequencer.sv
// Program counter and req/ack fetch sequencer (IDLE/FETCH/HOLD).
// Optional misaligned-redirect trap enabled by PC_MISALIGN_TRAP_EN.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_Plus4,
  input  logic        c_out,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        pc_wrap,
  output logic        misalign_trap,
  output logic [31:0] bad_target
);

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        redirect;
  logic [31:0] redir_pc;

  assign imem_req = (state == FETCH);
  assign redirect = branch_taken && (state != IDLE);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic trap_hit;

  assign trap_hit = redirect && (branch_target[1:0] != 2'b00);
  assign redir_pc = trap_hit ? TRAP_VECTOR : branch_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_trap <= 1'b0;
      bad_target    <= 32'h0;
    end else begin
      misalign_trap <= trap_hit;
      if (trap_hit)
        bad_target <= branch_target;
    end
  end
`else
  assign redir_pc      = branch_target & 32'hFFFF_FFFC;
  assign misalign_trap = 1'b0;
  assign bad_target    = 32'h0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      PC          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0;
      pc_wrap     <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      // a redirect discards any ack landing in the same cycle
      if (redirect) begin
        PC    <= redir_pc;
        state <= FETCH;
      end else begin
        case (state)
          IDLE: state <= FETCH;
          FETCH: begin
            if (imem_ack) begin
              fetch_pc    <= PC;
              fetch_valid <= 1'b1;
              if (stall) begin
                state <= HOLD;
              end else begin
                PC <= PC_Plus4;
                if (c_out)
                  pc_wrap <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              PC    <= PC_Plus4;
              state <= FETCH;
              if (c_out)
                pc_wrap <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
